// File: rtl/bidi_message_queue_mc_if.sv
// Bus and stream bundle for bidi_message_queue_mc.
// The master side is the bus master plus the hardware endpoints; the queue is the slave.
interface bidi_message_queue_mc_if #(
   parameter int NUM_CHANNELS = 2,
   parameter int DEPTH_BITS   = 6,
   parameter int DATA_WIDTH   = 32
);
   localparam int CH_BITS   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam int ADDR_BITS = 2 + CH_BITS + DEPTH_BITS;

   logic [ADDR_BITS-1:0]                 mem_addr;
   logic                                 mem_read_en;
   logic                                 mem_write_en;
   logic [DATA_WIDTH-1:0]                mem_write_data;
   logic [DATA_WIDTH-1:0]                mem_read_data;
   logic [NUM_CHANNELS-1:0]              in_valid;
   logic [NUM_CHANNELS-1:0]              in_ready;
   logic [NUM_CHANNELS*DATA_WIDTH-1:0]   in_data;
   logic [NUM_CHANNELS-1:0]              out_valid;
   logic [NUM_CHANNELS-1:0]              out_ready;
   logic [NUM_CHANNELS*DATA_WIDTH-1:0]   out_data;
   logic                                 irq;

   modport master (
      output mem_addr, mem_read_en, mem_write_en, mem_write_data,
      output in_valid, in_data, out_ready,
      input  mem_read_data, in_ready, out_valid, out_data, irq
   );

   modport slave (
      input  mem_addr, mem_read_en, mem_write_en, mem_write_data,
      input  in_valid, in_data, out_ready,
      output mem_read_data, in_ready, out_valid, out_data, irq
   );
endinterface

// File: rtl/bidi_message_queue_mc.sv
// Multi-channel bidirectional message queue: per channel an inbound ring
// (hardware push, software pop) and an outbound ring (software push, hardware
// pop), software-visible pointers/status, and a maskable level interrupt.

// One channel: both rings, their pointers, err flag and interrupt enables.
module bidi_message_queue_mc_ch #(
   parameter int DEPTH_BITS = 6,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  reg_wr,
   input  logic [2:0]            reg_sel,
   input  logic                  data_wr,
   input  logic                  data_dir,
   input  logic [DEPTH_BITS-1:0] data_idx,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [DATA_WIDTH-1:0] reg_rdata,
   output logic [DATA_WIDTH-1:0] win_rdata,
   output logic                  pend_nxt
);
   localparam int DEPTH = 1 << DEPTH_BITS;
   localparam int PW    = DEPTH_BITS + 1;
   localparam logic [PW-1:0] DEPTH_P = {1'b1, {DEPTH_BITS{1'b0}}};

   logic [DATA_WIDTH-1:0] in_mem  [DEPTH];
   logic [DATA_WIDTH-1:0] out_mem [DEPTH];

   logic [PW-1:0] in_wr, in_rd, out_wr, out_rd;
   logic [PW-1:0] in_wr_nxt, in_rd_nxt, out_wr_nxt, out_rd_nxt;
   logic          err, err_nxt;
   logic [2:0]    irq_en, irq_en_nxt;
   logic [PW-1:0] in_occ, out_occ, in_occ_nxt, out_occ_nxt, wr_ptr;
   logic          in_empty, in_full, out_empty, out_full;
   logic          push, pop, in_rd_ok, out_wr_ok;
   logic [2:0]    pend;
   logic          unused_wdata;

   assign in_occ    = in_wr - in_rd;
   assign out_occ   = out_wr - out_rd;
   assign in_empty  = (in_occ == '0);
   assign in_full   = (in_occ == DEPTH_P);
   assign out_empty = (out_occ == '0);
   assign out_full  = (out_occ == DEPTH_P);

   assign in_ready  = ~in_full;
   assign out_valid = ~out_empty;
   assign out_data  = out_mem[out_rd[DEPTH_BITS-1:0]];
   assign push      = in_valid & ~in_full;
   assign pop       = out_ready & ~out_empty;

   // Software pointer moves are bounded by what is actually there (inbound)
   // or free (outbound), judged on pointers before this cycle's push/pop.
   assign wr_ptr    = wdata[DEPTH_BITS:0];
   assign in_rd_ok  = (wr_ptr - in_rd) <= in_occ;
   assign out_wr_ok = (wr_ptr - out_wr) <= (DEPTH_P - out_occ);

   assign pend         = irq_en & {err, ~out_full, ~in_empty};
   assign unused_wdata = ^wdata;

   // Next-state for pointers, err and enables; also feeds the registered irq.
   always_comb begin
      in_wr_nxt  = in_wr + PW'(push);
      out_rd_nxt = out_rd + PW'(pop);
      in_rd_nxt  = in_rd;
      out_wr_nxt = out_wr;
      err_nxt    = err;
      irq_en_nxt = irq_en;
      if (reg_wr) begin
         case (reg_sel)
            3'd0: if (in_rd_ok) in_rd_nxt = wr_ptr; else err_nxt = 1'b1;
            3'd3: if (out_wr_ok) out_wr_nxt = wr_ptr; else err_nxt = 1'b1;
            3'd4: if (wdata[4]) err_nxt = 1'b0;
            3'd5: irq_en_nxt = wdata[2:0];
            default: ;
         endcase
      end
      in_occ_nxt  = in_wr_nxt - in_rd_nxt;
      out_occ_nxt = out_wr_nxt - out_rd_nxt;
      pend_nxt    = |(irq_en_nxt & {err_nxt, out_occ_nxt != DEPTH_P, in_occ_nxt != '0});
   end

   // Control state, cleared asynchronously so every ring empties at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_wr  <= '0;
         in_rd  <= '0;
         out_wr <= '0;
         out_rd <= '0;
         err    <= 1'b0;
         irq_en <= '0;
      end else begin
         in_wr  <= in_wr_nxt;
         in_rd  <= in_rd_nxt;
         out_wr <= out_wr_nxt;
         out_rd <= out_rd_nxt;
         err    <= err_nxt;
         irq_en <= irq_en_nxt;
      end
   end

   // Ring storage; hardware fills inbound, software fills outbound.
   always_ff @(posedge clk) begin
      if (push)    in_mem[in_wr[DEPTH_BITS-1:0]] <= in_data;
      if (data_wr) out_mem[data_idx]             <= wdata;
   end

   // Register and window read values for the bus mux.
   always_comb begin
      reg_rdata = '0;
      case (reg_sel)
         3'd0: reg_rdata = DATA_WIDTH'(in_rd);
         3'd1: reg_rdata = DATA_WIDTH'(in_wr);
         3'd2: reg_rdata = DATA_WIDTH'(out_rd);
         3'd3: reg_rdata = DATA_WIDTH'(out_wr);
         3'd4: reg_rdata = DATA_WIDTH'({err, out_full, out_empty, in_full, in_empty});
         3'd5: reg_rdata = DATA_WIDTH'(irq_en);
         3'd6: reg_rdata = DATA_WIDTH'(pend);
         default: reg_rdata = '0;
      endcase
      win_rdata = data_dir ? out_mem[data_idx] : in_mem[data_idx];
   end
endmodule

module bidi_message_queue_mc #(
   parameter int NUM_CHANNELS = 2,
   parameter int DEPTH_BITS   = 6,
   parameter int DATA_WIDTH   = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   bidi_message_queue_mc_if.slave   bus
);
   localparam int CH_BITS   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam int ADDR_BITS = 2 + CH_BITS + DEPTH_BITS;

   logic                  space, data_dir;
   logic [CH_BITS-1:0]    reg_ch, data_ch;
   logic [2:0]            reg_sel;
   logic [DEPTH_BITS-1:0] data_idx;

   logic [NUM_CHANNELS-1:0]                 reg_wr, data_wr, pend_nxt, in_ready, out_valid;
   logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] reg_rdata, win_rdata, out_word;
   logic [DATA_WIDTH-1:0]                   rd_val, rdata_q;
   logic                                    irq_q;

   assign space    = bus.mem_addr[ADDR_BITS-1];
   assign reg_ch   = bus.mem_addr[CH_BITS+2:3];
   assign reg_sel  = bus.mem_addr[2:0];
   assign data_ch  = bus.mem_addr[DEPTH_BITS+CH_BITS:DEPTH_BITS+1];
   assign data_dir = bus.mem_addr[DEPTH_BITS];
   assign data_idx = bus.mem_addr[DEPTH_BITS-1:0];

   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
      // Inbound-window writes are dropped here by never decoding them.
      assign reg_wr[c]  = bus.mem_write_en & ~space & (reg_ch == CH_BITS'(c));
      assign data_wr[c] = bus.mem_write_en & space & data_dir & (data_ch == CH_BITS'(c));

      bidi_message_queue_mc_ch #(
         .DEPTH_BITS (DEPTH_BITS),
         .DATA_WIDTH (DATA_WIDTH)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .reg_wr    (reg_wr[c]),
         .reg_sel   (reg_sel),
         .data_wr   (data_wr[c]),
         .data_dir  (data_dir),
         .data_idx  (data_idx),
         .wdata     (bus.mem_write_data),
         .in_valid  (bus.in_valid[c]),
         .in_data   (bus.in_data[c*DATA_WIDTH +: DATA_WIDTH]),
         .in_ready  (in_ready[c]),
         .out_valid (out_valid[c]),
         .out_ready (bus.out_ready[c]),
         .out_data  (out_word[c]),
         .reg_rdata (reg_rdata[c]),
         .win_rdata (win_rdata[c]),
         .pend_nxt  (pend_nxt[c])
      );

      assign bus.out_data[c*DATA_WIDTH +: DATA_WIDTH] = out_word[c];
   end

   // Select the addressed channel's value; unpopulated channels read 0.
   always_comb begin
      rd_val = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (!space && reg_ch == CH_BITS'(c))  rd_val = reg_rdata[c];
         if (space  && data_ch == CH_BITS'(c)) rd_val = win_rdata[c];
      end
   end

   // Registered read data (held between accesses, zeroed on writes) and irq.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
         irq_q   <= 1'b0;
      end else begin
         if (bus.mem_write_en)     rdata_q <= '0;
         else if (bus.mem_read_en) rdata_q <= rd_val;
         irq_q <= |pend_nxt;
      end
   end

   assign bus.mem_read_data = rdata_q;
   assign bus.irq           = irq_q;
   assign bus.in_ready      = in_ready;
   assign bus.out_valid     = out_valid;
endmodule

// File: tb/tb_bidi_message_queue_mc.sv
// Directed bench for bidi_message_queue_mc: 2 channels, 64-word rings, 32-bit words.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_bidi_message_queue_mc;
   localparam int NC = 2;
   localparam int DB = 6;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   logic [31:0] rd;

   bidi_message_queue_mc_if #(.NUM_CHANNELS(NC), .DEPTH_BITS(DB), .DATA_WIDTH(DW)) bus ();

   bidi_message_queue_mc #(.NUM_CHANNELS(NC), .DEPTH_BITS(DB), .DATA_WIDTH(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] ra(input int ch, input int r);
      return 9'(ch * 8 + r);
   endfunction

   function automatic logic [8:0] da(input int ch, input int dir, input int idx);
      return 9'(256 + ch * 128 + dir * 64 + idx);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic bus_wr(input logic [8:0] a, input logic [31:0] d);
      bus.mem_addr = a; bus.mem_write_data = d; bus.mem_write_en = 1'b1;
      tick();
      bus.mem_write_en = 1'b0;
   endtask

   task automatic bus_rd(input logic [8:0] a, output logic [31:0] d);
      bus.mem_addr = a; bus.mem_read_en = 1'b1;
      tick();
      bus.mem_read_en = 1'b0;
      d = bus.mem_read_data;
   endtask

   task automatic push(input int ch, input logic [31:0] w);
      bus.in_valid[ch] = 1'b1;
      bus.in_data[ch*32 +: 32] = w;
      tick();
      bus.in_valid[ch] = 1'b0;
   endtask

   initial begin
      bus.mem_addr = '0; bus.mem_read_en = 1'b0; bus.mem_write_en = 1'b0;
      bus.mem_write_data = '0; bus.in_valid = '0; bus.in_data = '0; bus.out_ready = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Reset state
      chk("rst_rdata", bus.mem_read_data, 32'h0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'h3);
      chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("rst_irq", 32'(bus.irq), 32'h0);
      bus_rd(ra(0, 4), rd); chk("rst_status0", rd, 32'h5);
      bus_rd(ra(1, 1), rd); chk("rst_in_wr1", rd, 32'h0);

      // Inbound fill on ch1, then free half and refill across the wrap
      for (int i = 0; i < 64; i++) push(1, 32'(i));
      chk("fill_in_ready", 32'(bus.in_ready), 32'h1);
      bus_rd(ra(1, 1), rd); chk("fill_in_wr", rd, 32'h40);
      bus_rd(ra(1, 4), rd); chk("fill_status1", rd, 32'h6);
      bus_rd(da(1, 0, 5), rd); chk("fill_word5", rd, 32'h5);
      bus_wr(ra(1, 0), 32'h20);
      chk("free_in_ready", 32'(bus.in_ready), 32'h3);
      for (int i = 64; i < 96; i++) push(1, 32'(i));
      chk("refill_in_ready", 32'(bus.in_ready), 32'h1);
      bus_rd(ra(1, 1), rd); chk("refill_in_wr", rd, 32'h60);
      bus_wr(ra(1, 0), 32'h60);
      bus_rd(ra(1, 0), rd); chk("drain_all_rd", rd, 32'h60);
      for (int i = 96; i < 128; i++) push(1, 32'(i));
      bus_rd(ra(1, 1), rd); chk("wrap_in_wr", rd, 32'h0);
      bus_rd(da(1, 0, 0), rd); chk("wrap_word0", rd, 32'd64);
      bus_rd(da(1, 0, 63), rd); chk("wrap_word63", rd, 32'd127);
      bus_rd(ra(1, 4), rd); chk("wrap_status1", rd, 32'h4);

      // Outbound on ch0
      bus_wr(da(0, 1, 0), 32'hA5A5);
      bus_wr(ra(0, 3), 32'h1);
      chk("out_valid_up", 32'(bus.out_valid), 32'h1);
      chk("out_data0", bus.out_data[31:0], 32'hA5A5);
      bus.out_ready[0] = 1'b1; tick(); bus.out_ready[0] = 1'b0;
      chk("out_valid_down", 32'(bus.out_valid), 32'h0);
      bus_rd(ra(0, 2), rd); chk("out_rd_ptr", rd, 32'h1);
      bus_rd(da(0, 1, 0), rd); chk("out_window", rd, 32'hA5A5);

      // Error on inbound ch0 and err interrupt
      push(0, 32'h100); push(0, 32'h101); push(0, 32'h102);
      bus_wr(ra(0, 5), 32'h4);
      chk("irq_quiet", 32'(bus.irq), 32'h0);
      bus_wr(ra(0, 0), 32'h5);
      chk("err_irq", 32'(bus.irq), 32'h1);
      bus_rd(ra(0, 0), rd); chk("err_rd_kept", rd, 32'h0);
      bus_rd(ra(0, 4), rd); chk("err_status", rd, 32'h14);
      bus_rd(ra(0, 6), rd); chk("err_pend", rd, 32'h4);
      bus_wr(ra(0, 4), 32'h10);
      chk("err_clr_irq", 32'(bus.irq), 32'h0);
      bus_rd(ra(0, 4), rd); chk("err_clr_status", rd, 32'h4);

      // Outbound capacity boundary: exactly DEPTH accepted, one more rejected
      bus_wr(ra(0, 3), 32'h41);
      bus_rd(ra(0, 4), rd); chk("out_full_status", rd, 32'h8);
      bus_wr(ra(0, 3), 32'h42);
      chk("out_over_irq", 32'(bus.irq), 32'h1);
      bus_rd(ra(0, 3), rd); chk("out_over_wr", rd, 32'h41);
      bus_rd(ra(0, 4), rd); chk("out_over_status", rd, 32'h18);
      bus_wr(ra(0, 4), 32'h10);
      bus_wr(ra(0, 2), 32'h5);
      bus_rd(ra(0, 2), rd); chk("ro_write_ignored", rd, 32'h1);
      bus_rd(ra(0, 4), rd); chk("ro_no_err", rd, 32'h8);

      // High write-data bits ignored; in_not_empty interrupt
      bus_wr(ra(0, 0), 32'hFFFF_FF81);
      bus_rd(ra(0, 0), rd); chk("high_bits_ignored", rd, 32'h1);
      bus_wr(ra(0, 5), 32'h1);
      chk("ine_irq", 32'(bus.irq), 32'h1);
      bus_rd(ra(0, 6), rd); chk("ine_pend", rd, 32'h1);
      bus_wr(ra(0, 5), 32'h0);
      chk("irq_off", 32'(bus.irq), 32'h0);

      // Simultaneous push and IN_RD_PTR write consuming all 63 words
      for (int i = 0; i < 61; i++) push(0, 32'(32'h200 + i));
      bus.in_valid[0] = 1'b1; bus.in_data[31:0] = 32'hBEEF;
      bus_wr(ra(0, 0), 32'h40);
      bus.in_valid[0] = 1'b0;
      bus_rd(ra(0, 1), rd); chk("sim_in_wr", rd, 32'h41);
      bus_rd(ra(0, 0), rd); chk("sim_in_rd", rd, 32'h40);
      bus_rd(ra(0, 4), rd); chk("sim_status", rd, 32'h8);
      bus_rd(da(0, 0, 0), rd); chk("sim_word", rd, 32'hBEEF);

      // Async reset mid-traffic
      bus.in_valid = 2'b11; bus.in_data = {32'h77, 32'h66};
      tick(); tick();
      chk("pre_rst_out_valid", 32'(bus.out_valid), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_in_ready", 32'(bus.in_ready), 32'h3);
      chk("arst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("arst_irq", 32'(bus.irq), 32'h0);
      bus.in_valid = 2'b00;
      #1 rst_n = 1'b1;
      tick();
      bus_rd(ra(0, 1), rd); chk("arst_in_wr0", rd, 32'h0);
      bus_rd(ra(1, 1), rd); chk("arst_in_wr1", rd, 32'h0);
      bus_rd(ra(0, 0), rd); chk("arst_in_rd0", rd, 32'h0);
      bus_rd(ra(0, 3), rd); chk("arst_out_wr0", rd, 32'h0);
      bus_rd(ra(0, 2), rd); chk("arst_out_rd0", rd, 32'h0);
      bus_rd(ra(0, 4), rd); chk("arst_status0", rd, 32'h5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
